// File: rtl/riscv_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : riscv_mem_pkg
// Brief  : Shared types and funct3 constants for the RV32I MEM stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        write_reg;
    logic        select;
    logic        mem_write;
  } ex_instr_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        write_reg;
    logic        select;
  } mem_wb_t;

  // Only the low two funct3 bits carry the access width; sign bit is irrelevant here.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    r = 1'b0;
    if (size == F3_H[1:0])      r = off[0];
    else if (size == F3_W[1:0]) r = (off != 2'b00);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_stage_if.sv
//------------------------------------------------------------------------------
// Module : memory_stage_if
// Brief  : Data-memory request/ready bus between the MEM stage and memory.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );
endinterface

`default_nettype wire

// File: rtl/store_unit.sv
//------------------------------------------------------------------------------
// Module : store_unit
// Brief  : Lane replication and byte-enable generation for stores.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_unit
  import riscv_mem_pkg::*;
(
  input  wire logic [31:0] i_rs2,
  input  wire logic [1:0]  i_size,
  input  wire logic [1:0]  i_off,
  input  wire logic        i_store,
  output logic      [31:0] o_wdata,
  output logic      [3:0]  o_be
);

  always_comb begin
    o_wdata = '0;
    o_be    = 4'b0000;
    if (i_store) begin
      // Halfword enables at offset 3 fall off the top and truncate to lane 3.
      if (i_size == F3_B[1:0]) begin
        o_wdata = {4{i_rs2[7:0]}};
        o_be    = 4'b0001 << i_off;
      end else if (i_size == F3_H[1:0]) begin
        o_wdata = {2{i_rs2[15:0]}};
        o_be    = 4'b0011 << i_off;
      end else begin
        o_wdata = i_rs2;
        o_be    = 4'hF;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
//------------------------------------------------------------------------------
// Module : memory_stage
// Brief  : RV32I MEM stage: dmem handshake, pipeline stall, MEM/WB register.
//          Optional MEM_MISALIGN_TRAP_EN adds misaligned-access trapping.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memory_stage
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_valid_from_execute,
  input  wire logic [31:0] i_result_from_execute,
  input  wire logic [31:0] i_rs2_from_execute,
  input  wire logic [2:0]  i_funct3_from_execute,
  input  wire logic [4:0]  i_rd_from_execute,
  input  wire logic        i_write_reg_from_execute,
  input  wire logic        i_select_from_execute,
  input  wire logic        i_mem_write_from_execute,
  memory_stage_if.master   dmem,
  output logic      [31:0] o_result_from_memory,
  output logic      [31:0] o_out_from_memory,
  output logic      [2:0]  o_funct3_from_memory,
  output logic      [4:0]  o_rd_from_memory,
  output logic             o_write_reg_from_memory,
  output logic             o_select_from_memory,
  output logic             o_stall_from_memory,
  output logic             o_bus_error
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             o_misalign_trap
`endif
);

  localparam logic [7:0] C_TIMEOUT = DMEM_TIMEOUT[7:0];

  mem_state_e r_state;
  logic [7:0] r_count;
  ex_instr_t  r_hold;
  mem_wb_t    r_mem_wb;
  logic       r_bus_error;

  ex_instr_t  w_ex;
  ex_instr_t  w_cur;
  mem_wb_t    w_wb_next;
  logic       w_in_wait;
  logic       w_mem_op;
  logic       w_misalign;
  logic       w_issue;
  logic       w_timeout;

  assign w_ex = '{result:    i_result_from_execute,
                  rs2:       i_rs2_from_execute,
                  funct3:    i_funct3_from_execute,
                  rd:        i_rd_from_execute,
                  write_reg: i_write_reg_from_execute,
                  select:    i_select_from_execute,
                  mem_write: i_mem_write_from_execute};

  assign w_in_wait = (r_state == WAIT);
  assign w_mem_op  = i_valid_from_execute & (i_select_from_execute | i_mem_write_from_execute);
  // While waiting, the bus is driven from the latched copy so EX may stay frozen.
  assign w_cur     = w_in_wait ? r_hold : w_ex;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = !w_in_wait & w_mem_op &
                      is_misaligned(i_funct3_from_execute[1:0], i_result_from_execute[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue   = w_in_wait | (w_mem_op & !w_misalign);
  assign w_timeout = w_in_wait & !dmem.dmem_ready & (r_count == C_TIMEOUT);

  assign w_wb_next = '{result:    w_cur.result,
                       rdata:     dmem.dmem_rdata,
                       funct3:    w_cur.funct3,
                       rd:        w_cur.rd,
                       write_reg: w_cur.write_reg,
                       select:    w_cur.select};

  assign dmem.dmem_req  = w_issue;
  assign dmem.dmem_we   = w_issue & w_cur.mem_write;
  assign dmem.dmem_addr = {w_cur.result[31:2], 2'b00};

  store_unit u_store_unit (
    .i_rs2   (w_cur.rs2),
    .i_size  (w_cur.funct3[1:0]),
    .i_off   (w_cur.result[1:0]),
    .i_store (w_issue & w_cur.mem_write),
    .o_wdata (dmem.dmem_wdata),
    .o_be    (dmem.dmem_be)
  );

  // The abort cycle releases the stall so the dropped instruction leaves EX.
  assign o_stall_from_memory = w_issue & !dmem.dmem_ready & !w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_hold      <= '0;
      r_mem_wb    <= '0;
      r_bus_error <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      o_misalign_trap <= 1'b0;
`endif
    end else begin
      r_bus_error <= w_timeout;
      r_mem_wb    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      o_misalign_trap <= w_misalign;
`endif
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            if (dmem.dmem_ready) begin
              r_mem_wb <= w_wb_next;
            end else begin
              r_state <= WAIT;
              r_hold  <= w_ex;
              r_count <= 8'd1;
            end
          end else if (i_valid_from_execute && !w_mem_op) begin
            r_mem_wb <= w_wb_next;
          end
        end
        WAIT: begin
          if (dmem.dmem_ready) begin
            r_mem_wb <= w_wb_next;
            r_state  <= IDLE;
            r_count  <= '0;
          end else if (w_timeout) begin
            r_state <= IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_result_from_memory    = r_mem_wb.result;
  assign o_out_from_memory       = r_mem_wb.rdata;
  assign o_funct3_from_memory    = r_mem_wb.funct3;
  assign o_rd_from_memory        = r_mem_wb.rd;
  assign o_write_reg_from_memory = r_mem_wb.write_reg;
  assign o_select_from_memory    = r_mem_wb.select;
  assign o_bus_error             = r_bus_error;

endmodule

`default_nettype wire
